btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; successor to the single-output board-button debouncer.
- Per channel: 2-FF synchroniser, settle counter that restarts on every bounce, stable level, one-cycle press/release pulses and a press-toggled latch.
- Sits between the board push-button pins and the game control FSM.
- Also provides aggregate any-button outputs so the FSM can keep using a single "a button was pressed" event.

Parameters:
- N_BTN, 4: number of button channels; minimum 1.
- SETTLE_CYCLES, 500000: consecutive stable cycles required before a change is accepted (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000: hold cycles before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat pulses. Used only with the optional feature.
- CNT_W, $clog2(SETTLE_CYCLES+1): localparam; settle counter width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  N_BTN  raw asynchronous button pins; 1 = pressed.
- btn_level  out  N_BTN  debounced level per channel.
- btn_press  out  N_BTN  one-cycle pulse on an accepted 0->1 transition (plus auto-repeat pulses when the feature is enabled).
- btn_release  out  N_BTN  one-cycle pulse on an accepted 1->0 transition.
- btn_toggle  out  N_BTN  inverts on every accepted press.
- any_level  out  1  OR of btn_level.
- any_press  out  1  OR of btn_press.

Behaviour:
- Reset: rst is sampled on the clk rising edge. It clears the synchroniser flops, counters, btn_level, btn_toggle and all pulse outputs to 0.
- Reset mid-count: the count is discarded. A button held through reset is seen as a fresh press after reset is released.
- Synchroniser: two flops per channel, s = second stage. Raw-pin latency into s is 2 edges.
- Settle counter, each cycle:
  - If s == btn_level, cnt <= 0. Any bounce restarts the count, unlike the predecessor.
  - Otherwise cnt increments.
  - When cnt == SETTLE_CYCLES-1 and s != btn_level still holds: btn_level <= s and cnt <= 0.
- Latency: a clean input step reaches btn_level exactly 2+SETTLE_CYCLES edges after it is first sampled.
- btn_press / btn_release: registered, asserted in the same cycle that btn_level first shows the new value, exactly one cycle wide. Never both high in one cycle.
- btn_toggle: flips in the cycle btn_press is asserted for a genuine press. Releases do not flip it.
- Pulse width shorter than SETTLE_CYCLES: no change on btn_level and no pulses.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.
- any_level and any_press are combinational ORs of the registered vectors.
- Counters saturate by construction: the wrap point is SETTLE_CYCLES-1, so no overflow is possible.
- Elaboration error if SETTLE_CYCLES < 1 or N_BTN < 1.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- Enabled:
  - Each channel gets a repeat counter that runs while btn_level == 1.
  - An extra one-cycle btn_press pulse fires REPEAT_DELAY cycles after the genuine press pulse, then every REPEAT_PERIOD cycles while the button stays held.
  - Repeat pulses do not flip btn_toggle.
  - The counter clears on release or rst.
- Disabled:
  - The repeat counter and its parameters have no logic.
  - btn_press fires exactly once per accepted press.

Decomposition:
- Package btn_pkg holds:
  - default constants: SETTLE_10MS_50MHZ = 500000, REPEAT_DELAY_500MS = 25000000, REPEAT_PERIOD_100MS = 5000000;
  - a function computing counter width.
- Sub-module btn_debounce_cell: one channel's synchroniser, settle counter, pulse/toggle logic and optional repeat logic.
- Top level: generate loop of N_BTN cells plus the OR reduction.

Test Plan (N_BTN=4, SETTLE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Reset: assert rst for 3 cycles with btn_in=4'b1111 -> all outputs 0 during reset. btn_level=4'b1111 and btn_press=4'b1111 for one cycle exactly 10 edges after rst deasserts.
- Clean press: ch0 steps 0->1 -> btn_level[0]=1 and btn_press[0]=1 exactly 10 edges later; btn_toggle[0]=1; any_press=1 in the same cycle.
- Bounce: ch1 toggles 1,0,1,0 with 3-cycle dwell, then holds 1 -> single btn_press[1] pulse 10 edges after the final edge; no earlier pulses.
- Glitch reject: ch2 high for 7 cycles, then low -> btn_level[2] stays 0; no btn_press or btn_release.
- Release plus simultaneous: ch0 released while ch3 pressed on the same edge -> btn_release[0] and btn_press[3] both 1 in one cycle; btn_toggle[0] unchanged.
- With BTN_DEBOUNCE_REPEAT_EN: hold ch0 for 40 cycles past acceptance -> btn_press[0] pulses at +0, +20, +25, +30, +35; btn_toggle[0] flips once only.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// Default timing assumes a 50 MHz system clock.
package btn_pkg;

    // 10 ms settle window at 50 MHz.
    localparam int SETTLE_10MS_50MHZ   = 500000;
    // 500 ms hold before the first auto-repeat press.
    localparam int REPEAT_DELAY_500MS  = 25000000;
    // 100 ms between later auto-repeat presses.
    localparam int REPEAT_PERIOD_100MS = 5000000;

    // Width needed to hold values 0..max_count. Never returns less than 1.
    function automatic int cnt_width(input int max_count);
        int w;
        w = (max_count < 1) ? 1 : $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button channel. It contains a 2-FF synchroniser, a settle counter
// that restarts on every bounce, the debounced level, one-cycle
// press/release pulses and a press-toggled latch.
// Optional auto-repeat is enabled by the macro BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_10MS_50MHZ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MS
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_toggle
);

    localparam int CNT_W = cnt_width(SETTLE_CYCLES);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("btn_debounce_cell: SETTLE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_cell: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_toggle;

    logic w_differs;
    logic w_accept;
    logic w_accept_press;
    logic w_accept_release;
    logic w_rep_fire;

    // A change is accepted once the synchronised input has disagreed with
    // the level for SETTLE_CYCLES consecutive cycles.
    assign w_differs        = (r_sync2 != r_level);
    assign w_accept         = w_differs && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_accept_press   = w_accept &&  r_sync2;
    assign w_accept_release = w_accept && !r_sync2;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Settle counter. Agreement clears it, so any bounce restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!w_differs) begin
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = cnt_width(REP_MAX);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;
    logic [REP_W-1:0] w_rep_target;

    // The first repeat waits REPEAT_DELAY cycles and later repeats wait
    // REPEAT_PERIOD cycles. A pending release suppresses the repeat so
    // press and release never coincide.
    assign w_rep_target = r_rep_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
    assign w_rep_fire   = r_level && !w_accept && (r_rep_cnt == w_rep_target);

    // Repeat counter. It runs only while the debounced level is high.
    always_ff @(posedge i_clk) begin
        if (i_rst || !r_level || w_accept) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt   <= r_rep_cnt + REP_W'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Registered pulses line up with the cycle in which the level changes.
    // Only genuine presses flip the toggle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_press   <= w_accept_press || w_rep_fire;
            r_release <= w_accept_release;
            if (w_accept_press) begin
                r_toggle <= ~r_toggle;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_toggle  = r_toggle;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner. It places one debounce cell per
// button pin and adds aggregate any-button outputs for the control FSM.
// Optional auto-repeat is enabled by the macro BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int SETTLE_CYCLES = SETTLE_10MS_50MHZ,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_500MS,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_100MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_toggle,
    output logic             any_level,
    output logic             any_press
);

    if (N_BTN < 1) begin : g_bad_nbtn
        $error("btn_debounce_multi: N_BTN must be >= 1");
    end

    // Every channel is fully independent.
    for (genvar g = 0; g < N_BTN; g++) begin : g_cell
        btn_debounce_cell #(
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_cell (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_btn     (btn_in[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_toggle  (btn_toggle[g])
        );
    end

    // Aggregate outputs are combinational ORs of the registered vectors.
    assign any_level = |btn_level;
    assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Testbench for btn_debounce_multi (N_BTN=4, SETTLE_CYCLES=8, REPEAT_DELAY=20,
// REPEAT_PERIOD=5). The repeat expectations follow BTN_DEBOUNCE_REPEAT_EN.
module tb_btn_debounce_multi;

    localparam int N      = 4;
    localparam int SETTLE = 8;
    localparam int RDLY   = 20;
    localparam int RPER   = 5;
    localparam int LAT    = SETTLE + 2;
    localparam int W      = 48;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_toggle;
    logic         any_level, any_press;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_debounce_multi #(
        .N_BTN         (N),
        .SETTLE_CYCLES (SETTLE),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_toggle  (btn_toggle),
        .any_level   (any_level),
        .any_press   (any_press)
    );

    // ---------------- scoreboard state ----------------
    // Each entry is {cycle[31:0], level, press, release, toggle}.
    logic [W-1:0] exp_q[$];
    logic [N-1:0] exp_level  = '0;
    logic [N-1:0] exp_toggle = '0;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Push the expected event for a level change to lvl at cycle 'at'.
    // rep adds auto-repeat press bits, which leave the toggle alone.
    task automatic push_ev(input int at, input logic [N-1:0] lvl, input logic [N-1:0] rep);
        logic [N-1:0] p, r;
        p = lvl & ~exp_level;
        r = exp_level & ~lvl;
        exp_toggle = exp_toggle ^ p;
        exp_level  = lvl;
        exp_q.push_back({32'(at), lvl, p | rep, r, exp_toggle});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v);
        btn_in = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   32'(btn_level),   32'd0);
        chk({tag, "_press"},   32'(btn_press),   32'd0);
        chk({tag, "_release"}, 32'(btn_release), 32'd0);
        chk({tag, "_toggle"},  32'(btn_toggle),  32'd0);
        chk({tag, "_any"},     32'({any_level, any_press}), 32'd0);
    endtask

    // ---------------- monitor ----------------
    // Any pulse or level change counts as a DUT event. It must match the
    // head of the expected queue, including the cycle it appears in.
    logic [N-1:0] prev_level = '0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            prev_level = btn_level;
        end else if (btn_press != '0 || btn_release != '0 || btn_level != prev_level) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: level=%b press=%b release=%b at cycle %0d, expected none",
                         btn_level, btn_press, btn_release, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ev_cycle",   32'(cyc),         e[47:16]);
                chk("ev_level",   32'(btn_level),   32'(e[15:12]));
                chk("ev_press",   32'(btn_press),   32'(e[11:8]));
                chk("ev_release", 32'(btn_release), 32'(e[7:4]));
                chk("ev_toggle",  32'(btn_toggle),  32'(e[3:0]));
                chk("ev_any_press", 32'(any_press), 32'(|e[11:8]));
                chk("ev_any_level", 32'(any_level), 32'(|e[15:12]));
            end
            prev_level = btn_level;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        rst    = 1'b1;
        btn_in = 4'b1111;

        // The reset is held for 3 edges with all buttons pressed.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_all_zero("reset");
        end
        rst = 1'b0;
        push_ev(cyc + LAT, 4'b1111, 4'b0000);
        tick(LAT + 3);

        // Release all buttons.
        drive(4'b0000);
        push_ev(cyc + LAT, 4'b0000, 4'b0000);
        tick(LAT + 3);

        // Clean press on ch0.
        drive(4'b0001);
        push_ev(cyc + LAT, 4'b0001, 4'b0000);
        tick(LAT + 3);

        // Bounce on ch1 with a 3-cycle dwell, then hold.
        drive(4'b0011); tick(3);
        drive(4'b0001); tick(3);
        drive(4'b0011); tick(3);
        drive(4'b0001); tick(3);
        drive(4'b0011);
        push_ev(cyc + LAT, 4'b0011, 4'b0000);
        tick(LAT + 3);

        // Glitch on ch2, high for one cycle less than the settle window.
        drive(4'b0111); tick(SETTLE - 1);
        drive(4'b0011);
        tick(LAT + 3);
        chk("glitch_level2", 32'(btn_level[2]), 32'd0);

        // Release ch0 and press ch3 on the same edge.
        drive(4'b1010);
        push_ev(cyc + LAT, 4'b1010, 4'b0000);
        tick(LAT + 3);

        drive(4'b0000);
        push_ev(cyc + LAT, 4'b0000, 4'b0000);
        tick(LAT + 3);

        // Long hold on ch0 (auto-repeat pulses when the feature is built in).
        drive(4'b0001);
        t0 = cyc;
        push_ev(t0 + LAT, 4'b0001, 4'b0000);
`ifdef BTN_DEBOUNCE_REPEAT_EN
        for (int k = 0; k < 6; k++) begin
            push_ev(t0 + LAT + RDLY + k * RPER, 4'b0001, 4'b0001);
        end
`endif
        tick(LAT + 38);
        drive(4'b0000);
        push_ev(cyc + LAT, 4'b0000, 4'b0000);
        tick(LAT + 3);
        chk("hold_toggle", 32'(btn_toggle), 32'(exp_toggle));

        // Reset mid-count while ch2 is held. After reset it is a fresh press.
        drive(4'b0100);
        tick(5);
        rst = 1'b1;
        exp_level  = '0;
        exp_toggle = '0;
        tick(1); chk_all_zero("midrst1");
        tick(1); chk_all_zero("midrst2");
        rst = 1'b0;
        push_ev(cyc + LAT, 4'b0100, 4'b0000);
        tick(LAT + 3);

        // Bounded drain of the expected queue.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
